// File: rtl/bsg_concentrate_pkg.sv
// Shared types and elaboration-time helpers for the static concentrator and its
// parallel-in/serial-out wrapper.
package bsg_concentrate_pkg;

  // Widest lane mask the helpers below understand; els_p may not exceed this.
  localparam int pattern_max_els_gp = 256;

  typedef enum logic {eIdle, eSend} state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int popcount(input logic [pattern_max_els_gp-1:0] pattern);
    int count = 0;
    for (int i = 0; i < pattern_max_els_gp; i++)
      count += int'(pattern[i]);
    return count;
  endfunction

  // Lane number of the n-th set bit (n counts from 0, ascending lane order).
  function automatic int nth_set_idx(input logic [pattern_max_els_gp-1:0] pattern,
                                     input int n);
    int seen = 0;
    int lane = 0;
    for (int i = 0; i < pattern_max_els_gp; i++) begin
      if (pattern[i] && (seen == n))
        lane = i;
      if (pattern[i])
        seen += 1;
    end
    return lane;
  endfunction

endpackage

// File: rtl/bsg_concentrate_static_piso_if.sv
// Ready/valid word input and valid/yumi element output of the concentrating PISO.
interface bsg_concentrate_static_piso_if
  import bsg_concentrate_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 32
);
  localparam int lg_els_lp = safe_clog2(els_p);

  logic                       v_i;
  logic [els_p*width_p-1:0]   data_i;
  logic                       ready_o;
  logic                       v_o;
  logic [width_p-1:0]         data_o;
  logic [lg_els_lp-1:0]       idx_o;
  logic                       last_o;
  logic                       yumi_i;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, idx_o, last_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, idx_o, last_o
  );

endinterface

// File: rtl/bsg_concentrate_static.sv
// Purely combinational packing of the lanes selected by a compile-time mask into
// a dense word, lowest kept lane first.
module bsg_concentrate_static
  import bsg_concentrate_pkg::*;
#(
  parameter int                            width_p       = 1,
  parameter int                            els_p         = 32,
  parameter logic [pattern_max_els_gp-1:0] pattern_els_p = pattern_max_els_gp'(32'hEDBF),
  parameter int                            sel_els_p     = popcount(pattern_els_p)
)
(
  input  logic [els_p*width_p-1:0]     data_i,
  output logic [sel_els_p*width_p-1:0] data_o
);

  for (genvar j = 0; j < sel_els_p; j++) begin : g_lane
    localparam int lane_lp = nth_set_idx(pattern_els_p, j);
    assign data_o[j*width_p +: width_p] = data_i[lane_lp*width_p +: width_p];
  end

  // Dropped lanes are intentionally left unconnected.
  logic unused_lanes;
  assign unused_lanes = ^data_i;

endmodule

// File: rtl/bsg_concentrate_static_piso.sv
// Captures one concentrated word, then emits its kept elements one per yumi with
// original lane index and a last flag.
module bsg_concentrate_static_piso
  import bsg_concentrate_pkg::*;
#(
  parameter int                            width_p       = 1,
  parameter int                            els_p         = 32,
  parameter logic [pattern_max_els_gp-1:0] pattern_els_p = pattern_max_els_gp'(32'hEDBF)
)
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  bsg_concentrate_static_piso_if.slave link
);

  localparam int sel_els_lp   = popcount(pattern_els_p);
  localparam int lg_els_lp    = safe_clog2(els_p);
  localparam int cnt_width_lp = safe_clog2(sel_els_lp);

  if ((pattern_els_p == '0) || (els_p > pattern_max_els_gp)
      || ((pattern_els_p >> els_p) != '0)) begin : g_bad_pattern
    $error("bsg_concentrate_static_piso: pattern_els_p must be nonzero and fit in els_p");
  end

  state_e                        state_r, state_n;
  logic [cnt_width_lp-1:0]       cnt_r, cnt_n;
  logic [sel_els_lp*width_p-1:0] held_r, held_n, packed_data;
  logic [lg_els_lp-1:0]          idx_tbl [sel_els_lp];
  logic                          ready, valid, last;

  bsg_concentrate_static #(
    .width_p      (width_p),
    .els_p        (els_p),
    .pattern_els_p(pattern_els_p),
    .sel_els_p    (sel_els_lp)
  ) conc (
    .data_i(link.data_i),
    .data_o(packed_data)
  );

  // Lane numbers are fixed by the mask, so the index lookup is a constant table.
  for (genvar j = 0; j < sel_els_lp; j++) begin : g_idx
    assign idx_tbl[j] = lg_els_lp'(nth_set_idx(pattern_els_p, j));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eIdle;
      cnt_r   <= '0;
      held_r  <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      held_r  <= held_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    held_n  = held_r;
    ready   = 1'b0;
    valid   = 1'b0;
    last    = 1'b0;
    unique case (state_r)
      eIdle: begin
        ready = 1'b1;
        if (link.v_i) begin
          held_n  = packed_data;
          cnt_n   = '0;
          state_n = eSend;
        end
      end
      eSend: begin
        valid = 1'b1;
        last  = (cnt_r == cnt_width_lp'(sel_els_lp - 1));
        if (link.yumi_i) begin
          if (last) state_n = eIdle;
          else      cnt_n   = cnt_r + 1'b1;
        end
      end
      default: state_n = eIdle;
    endcase
  end

  // Handshake outputs are forced low while reset is held, even before the edge.
  assign link.ready_o = ready & ~reset_i;
  assign link.v_o     = valid & ~reset_i;
  assign link.last_o  = last & ~reset_i;
  assign link.data_o  = held_r[int'(cnt_r)*width_p +: width_p];
  assign link.idx_o   = idx_tbl[cnt_r];

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      yumi_only_when_valid: assert (!(link.yumi_i && (state_r != eSend)));
  end

endmodule

// File: tb/tb_bsg_concentrate_static_piso.sv
// Scoreboard bench: a lane model queues expected beats per word, a negedge monitor
// compares every valid beat, plus a small second instance for the wide-element case.
module tb_bsg_concentrate_static_piso;
  import bsg_concentrate_pkg::*;

  localparam logic [pattern_max_els_gp-1:0] pattern_lp  = pattern_max_els_gp'(32'hEDBF);
  localparam logic [pattern_max_els_gp-1:0] pattern2_lp = pattern_max_els_gp'(4'b1010);

  typedef struct {
    logic [7:0] data;
    int         idx;
    logic       last;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  consume_en = 1'b0;
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  int    last_pop_cyc = -1;
  beat_t exp_q[$];
  int    acc_cycles[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_concentrate_static_piso_if #(.width_p(1), .els_p(32)) link ();
  bsg_concentrate_static_piso_if #(.width_p(8), .els_p(4))  link2 ();

  // The consumer only ever pulls when something is offered.
  assign link.yumi_i  = link.v_o & consume_en;
  assign link2.yumi_i = link2.v_o & consume_en;

  bsg_concentrate_static_piso #(
    .width_p(1), .els_p(32), .pattern_els_p(pattern_lp)
  ) dut (
    .clk_i(clk), .reset_i(reset), .link(link)
  );

  bsg_concentrate_static_piso #(
    .width_p(8), .els_p(4), .pattern_els_p(pattern2_lp)
  ) dut2 (
    .clk_i(clk), .reset_i(reset), .link(link2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic void modelWord(input logic [31:0] word);
    int    top = -1;
    beat_t b;
    for (int k = 0; k < 32; k++)
      if (pattern_lp[k]) top = k;
    for (int k = 0; k < 32; k++) begin
      if (pattern_lp[k]) begin
        b.data = {7'b0, word[k]};
        b.idx  = k;
        b.last = (k == top);
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (link.v_i && link.ready_o)
        acc_cycles.push_back(cyc);
      if (link.v_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_v", 32'(link.v_o), 32'd0);
        end else begin
          checkOutput("data", 32'(link.data_o), 32'(exp_q[0].data));
          checkOutput("idx", 32'(link.idx_o), 32'(exp_q[0].idx));
          checkOutput("last", 32'(link.last_o), 32'(exp_q[0].last));
          checkOutput("ready_in_send", 32'(link.ready_o), 32'd0);
          if (link.yumi_i) begin
            if (exp_q[0].last) last_pop_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] word);
    int guard = 0;
    while (link.ready_o !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
    end else begin
      link.data_i = word;
      link.v_i    = 1'b1;
      modelWord(word);
      @(posedge clk); #1;
      link.v_i    = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((exp_q.size() != 0 || link.v_o) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdx(input int idx);
    int guard = 0;
    while (!(link.v_o && int'(link.idx_o) == idx) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("idx_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int guard;
    link.v_i = 1'b0;  link.data_i = '0;
    link2.v_i = 1'b0; link2.data_i = '0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_ready", 32'(link.ready_o), 32'd0);
    checkOutput("reset_v", 32'(link.v_o), 32'd0);
    checkOutput("reset_last", 32'(link.last_o), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 32'(link.ready_o), 32'd1);

    $display("[TB] basic word");
    consume_en = 1'b1;
    applyStimulus(32'h0000A5A5);
    waitDrain();

    $display("[TB] masked lanes only");
    applyStimulus(32'hFFFF1240);
    waitDrain();

    $display("[TB] backpressure at beat 3");
    applyStimulus(32'h0000A5A5);
    waitIdx(3);
    consume_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_idx", 32'(link.idx_o), 32'd3);
      checkOutput("stall_data", 32'(link.data_o), 32'd0);
    end
    @(posedge clk); #1;
    consume_en = 1'b1;
    waitDrain();

    $display("[TB] back-to-back words");
    acc_cycles.delete();
    link.data_i = 32'h12345678;
    link.v_i    = 1'b1;
    modelWord(32'h12345678);
    guard = 0;
    while (acc_cycles.size() < 1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    link.data_i = 32'h9ABCDEF0;
    modelWord(32'h9ABCDEF0);
    guard = 0;
    while (acc_cycles.size() < 2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    link.v_i = 1'b0;
    waitDrain();
    checkOutput("b2b_accepts", 32'(acc_cycles.size()), 32'd2);
    if (acc_cycles.size() == 2) begin
      checkOutput("b2b_second_accept", 32'(acc_cycles[1] - acc_cycles[0]), 32'd14);
      checkOutput("b2b_total", 32'(last_pop_cyc - acc_cycles[0] + 1), 32'd28);
    end

    $display("[TB] reset mid-word");
    applyStimulus(32'h0000A5A5);
    waitIdx(4);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("v_in_reset", 32'(link.v_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_mid_reset", 32'(link.ready_o), 32'd1);
    @(posedge clk); #1;
    applyStimulus(32'h0000FFFF);
    checkOutput("restart_idx", 32'(link.idx_o), 32'd0);
    waitDrain();

    $display("[TB] wide elements, sparse 4-lane mask");
    checkOutput("alt_ready", 32'(link2.ready_o), 32'd1);
    link2.data_i = 32'hDDCCBBAA;
    link2.v_i    = 1'b1;
    @(posedge clk); #1;
    link2.v_i    = 1'b0;
    checkOutput("alt_beat0_v", 32'(link2.v_o), 32'd1);
    checkOutput("alt_beat0_data", 32'(link2.data_o), 32'hBB);
    checkOutput("alt_beat0_idx", 32'(link2.idx_o), 32'd1);
    checkOutput("alt_beat0_last", 32'(link2.last_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("alt_beat1_data", 32'(link2.data_o), 32'hDD);
    checkOutput("alt_beat1_idx", 32'(link2.idx_o), 32'd3);
    checkOutput("alt_beat1_last", 32'(link2.last_o), 32'd1);
    @(posedge clk); #1;
    checkOutput("alt_done_v", 32'(link2.v_o), 32'd0);
    checkOutput("alt_done_ready", 32'(link2.ready_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
